// File: rtl/popcount_window_stats.sv
// Windowed sum/min/max of the popcount stream: groups WINDOW accepted samples
// and reports the window statistics with a one-cycle valid pulse.
module popcount_window_stats #(
    parameter int WIDTH  = 5,
    parameter int WINDOW = 8,
    localparam int CNT_W = $clog2(WIDTH) + 2,
    localparam int SUM_W = $clog2(WIDTH * WINDOW + 1)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cnt_val_i,
    input  logic             clear_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o,
    output logic             stats_val_o,
    output logic             busy_o,
    output logic             range_err_o
);

    localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] MAX_SAMPLE = CNT_W'(WIDTH);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] rmin;
    logic [CNT_W-1:0] rmax;

    function automatic logic [CNT_W-1:0] sat_sample(input logic [CNT_W-1:0] v);
        return (v > MAX_SAMPLE) ? MAX_SAMPLE : v;
    endfunction

    function automatic logic [CNT_W-1:0] min_of(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [CNT_W-1:0] max_of(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic             accept;
    logic             first;
    logic             last;
    logic             out_of_range;
    logic [CNT_W-1:0] samp;
    logic [SUM_W-1:0] acc_nxt;
    logic [CNT_W-1:0] rmin_nxt;
    logic [CNT_W-1:0] rmax_nxt;

    always_comb begin
        accept       = cnt_val_i & ~clear_i;
        first        = (idx == '0);
        last         = (idx == LAST_IDX);
        out_of_range = (cnt_i > MAX_SAMPLE);
        samp         = sat_sample(cnt_i);
        // A fresh window loads the sample instead of folding it into stale values.
        acc_nxt      = first ? SUM_W'(samp) : acc + SUM_W'(samp);
        rmin_nxt     = first ? samp : min_of(rmin, samp);
        rmax_nxt     = first ? samp : max_of(rmax, samp);
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy_o = (state_q == ACCUM);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            idx  <= '0;
            acc  <= '0;
            rmin <= '0;
            rmax <= '0;
        end else if (clear_i) begin
            idx <= '0;
        end else if (accept) begin
            acc  <= acc_nxt;
            rmin <= rmin_nxt;
            rmax <= rmax_nxt;
            idx  <= last ? '0 : idx + IDX_W'(1);
        end
    end

    // Window results: updated only on the completing sample, held otherwise.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sum_o       <= '0;
            min_o       <= '0;
            max_o       <= '0;
            stats_val_o <= 1'b0;
        end else begin
            stats_val_o <= accept & last;
            if (accept && last) begin
                sum_o <= acc_nxt;
                min_o <= rmin_nxt;
                max_o <= rmax_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            range_err_o <= 1'b0;
        end else if (clear_i) begin
            range_err_o <= 1'b0;
        end else if (accept && out_of_range) begin
            range_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Directed bench for popcount_window_stats: a WINDOW=4 instance driven from a
// vector table plus hand sequences, and a WINDOW=1 instance for the degenerate case.
module tb_popcount_window_stats;

    localparam int WIDTH = 5;
    localparam int CNT_W = $clog2(WIDTH) + 2;
    localparam int SUM_W4 = $clog2(WIDTH * 4 + 1);
    localparam int SUM_W1 = $clog2(WIDTH * 1 + 1);

    logic clk_i = 1'b0;
    logic arst_n_i = 1'b0;

    logic [CNT_W-1:0]  cnt_i = '0;
    logic              cnt_val_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [SUM_W4-1:0] sum_o;
    logic [CNT_W-1:0]  min_o;
    logic [CNT_W-1:0]  max_o;
    logic              stats_val_o;
    logic              busy_o;
    logic              range_err_o;

    logic [CNT_W-1:0]  w1_cnt = '0;
    logic              w1_val = 1'b0;
    logic              w1_clr = 1'b0;
    logic [SUM_W1-1:0] w1_sum;
    logic [CNT_W-1:0]  w1_min;
    logic [CNT_W-1:0]  w1_max;
    logic              w1_stv;
    logic              w1_busy;
    logic              w1_err;

    always #5 clk_i = ~clk_i;

    popcount_window_stats #(.WIDTH(WIDTH), .WINDOW(4)) u_dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cnt_i       (cnt_i),
        .cnt_val_i   (cnt_val_i),
        .clear_i     (clear_i),
        .sum_o       (sum_o),
        .min_o       (min_o),
        .max_o       (max_o),
        .stats_val_o (stats_val_o),
        .busy_o      (busy_o),
        .range_err_o (range_err_o)
    );

    popcount_window_stats #(.WIDTH(WIDTH), .WINDOW(1)) u_w1 (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cnt_i       (w1_cnt),
        .cnt_val_i   (w1_val),
        .clear_i     (w1_clr),
        .sum_o       (w1_sum),
        .min_o       (w1_min),
        .max_o       (w1_max),
        .stats_val_o (w1_stv),
        .busy_o      (w1_busy),
        .range_err_o (w1_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_main(input string tag, input int s, input int mn, input int mx,
                              input int stv, input int bsy, input int err);
        check({tag, " sum"},  int'(sum_o),       s);
        check({tag, " min"},  int'(min_o),       mn);
        check({tag, " max"},  int'(max_o),       mx);
        check({tag, " stv"},  int'(stats_val_o), stv);
        check({tag, " busy"}, int'(busy_o),      bsy);
        check({tag, " err"},  int'(range_err_o), err);
    endtask

    // Drive one cycle of inputs, then look at the registered result 1 ns after the edge.
    task automatic step(input logic v, input int c, input logic clr);
        cnt_val_i = v;
        cnt_i     = CNT_W'(c);
        clear_i   = clr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_w1(input logic v, input int c, input logic clr);
        w1_val = v;
        w1_cnt = CNT_W'(c);
        w1_clr = clr;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic v;
        int   c;
        logic clr;
        int   e_sum;
        int   e_min;
        int   e_max;
        int   e_stv;
        int   e_busy;
        int   e_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // v, cnt, clr, sum, min, max, stv, busy, err (state seen right after the edge)
        // 3,0,5,2
        tbl.push_back('{1'b1, 3, 1'b0,  0, 0, 0, 0, 1, 0});
        tbl.push_back('{1'b1, 0, 1'b0,  0, 0, 0, 0, 1, 0});
        tbl.push_back('{1'b1, 5, 1'b0,  0, 0, 0, 0, 1, 0});
        tbl.push_back('{1'b1, 2, 1'b0, 10, 0, 5, 1, 0, 0});
        // 1,1,1,1 then 4,4,4,4 back to back
        tbl.push_back('{1'b1, 1, 1'b0, 10, 0, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 1, 1'b0, 10, 0, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 1, 1'b0, 10, 0, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 1, 1'b0,  4, 1, 1, 1, 0, 0});
        tbl.push_back('{1'b1, 4, 1'b0,  4, 1, 1, 0, 1, 0});
        tbl.push_back('{1'b1, 4, 1'b0,  4, 1, 1, 0, 1, 0});
        tbl.push_back('{1'b1, 4, 1'b0,  4, 1, 1, 0, 1, 0});
        tbl.push_back('{1'b1, 4, 1'b0, 16, 4, 4, 1, 0, 0});
        // 2,_,_,5,_,3,1 with gaps, then an idle cycle
        tbl.push_back('{1'b1, 2, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b0, 7, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b0, 0, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b1, 5, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b0, 1, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b1, 3, 1'b0, 16, 4, 4, 0, 1, 0});
        tbl.push_back('{1'b1, 1, 1'b0, 11, 1, 5, 1, 0, 0});
        tbl.push_back('{1'b0, 0, 1'b0, 11, 1, 5, 0, 0, 0});
        // 5,5, clear (with a valid sample that must be dropped), then 1,2,3,4
        tbl.push_back('{1'b1, 5, 1'b0, 11, 1, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 5, 1'b0, 11, 1, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 5, 1'b1, 11, 1, 5, 0, 0, 0});
        tbl.push_back('{1'b1, 1, 1'b0, 11, 1, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 2, 1'b0, 11, 1, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 3, 1'b0, 11, 1, 5, 0, 1, 0});
        tbl.push_back('{1'b1, 4, 1'b0, 10, 1, 4, 1, 0, 0});
        // 7 (clamped to 5, sets err), 0,0,0, then clear drops err
        tbl.push_back('{1'b1, 7, 1'b0, 10, 1, 4, 0, 1, 1});
        tbl.push_back('{1'b1, 0, 1'b0, 10, 1, 4, 0, 1, 1});
        tbl.push_back('{1'b1, 0, 1'b0, 10, 1, 4, 0, 1, 1});
        tbl.push_back('{1'b1, 0, 1'b0,  5, 0, 5, 1, 0, 1});
        tbl.push_back('{1'b0, 0, 1'b1,  5, 0, 5, 0, 0, 0});
        // out-of-range sample together with clear is discarded: no err, no window
        tbl.push_back('{1'b1, 9, 1'b1,  5, 0, 5, 0, 0, 0});
        tbl.push_back('{1'b0, 0, 1'b0,  5, 0, 5, 0, 0, 0});

        // Reset state
        #12;
        check_main("reset", 0, 0, 0, 0, 0, 0);
        check("w1 reset stv", int'(w1_stv), 0);
        check("w1 reset sum", int'(w1_sum), 0);
        @(posedge clk_i);
        #1 arst_n_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].clr);
            check_main($sformatf("vec%0d", i), tbl[i].e_sum, tbl[i].e_min, tbl[i].e_max,
                       tbl[i].e_stv, tbl[i].e_busy, tbl[i].e_err);
        end

        // Reset mid-window takes effect immediately, then a clean window of 3s.
        step(1'b1, 5, 1'b0);
        step(1'b1, 3, 1'b0);
        check_main("pre_rst", 5, 0, 5, 0, 1, 0);
        step(1'b1, 7, 1'b0);
        check_main("pre_rst_err", 5, 0, 5, 0, 1, 1);
        cnt_val_i = 1'b0;
        #2 arst_n_i = 1'b0;
        #1;
        check_main("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        step(1'b1, 3, 1'b0);
        check_main("post_rst1", 0, 0, 0, 0, 1, 0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b0);
        check_main("post_rst3", 0, 0, 0, 0, 1, 0);
        step(1'b1, 3, 1'b0);
        check_main("post_rst_win", 12, 3, 3, 1, 0, 0);
        step(1'b0, 0, 1'b0);
        check_main("post_rst_hold", 12, 3, 3, 0, 0, 0);

        // WINDOW == 1: every sample completes a window, busy never rises.
        step_w1(1'b1, 3, 1'b0);
        check("w1 s3 stv", int'(w1_stv), 1);
        check("w1 s3 sum", int'(w1_sum), 3);
        check("w1 s3 min", int'(w1_min), 3);
        check("w1 s3 max", int'(w1_max), 3);
        check("w1 s3 busy", int'(w1_busy), 0);
        step_w1(1'b1, 4, 1'b0);
        check("w1 s4 stv", int'(w1_stv), 1);
        check("w1 s4 sum", int'(w1_sum), 4);
        check("w1 s4 max", int'(w1_max), 4);
        check("w1 s4 busy", int'(w1_busy), 0);
        step_w1(1'b1, 9, 1'b0);
        check("w1 clamp sum", int'(w1_sum), 5);
        check("w1 clamp min", int'(w1_min), 5);
        check("w1 clamp err", int'(w1_err), 1);
        step_w1(1'b1, 2, 1'b1);
        check("w1 clr stv", int'(w1_stv), 0);
        check("w1 clr sum", int'(w1_sum), 5);
        check("w1 clr err", int'(w1_err), 0);
        step_w1(1'b0, 0, 1'b0);
        check("w1 idle stv", int'(w1_stv), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
